// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end for a 16-bit machine with one- and two-word
// instructions. It streams addresses to a synchronous instruction memory,
// pairs each Ldl opcode (word[15:4] == LIT_OPC) with the literal word that
// follows it, and presents complete instructions on a valid/ready interface.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous active-high reset
//   i_addr       instruction address to memory (combinational)
//   i_bus        memory data for the address presented on the previous edge
//   redirect     one-cycle request to restart fetch at redirect_pc
//   redirect_pc  restart address, valid while redirect is high
//   inst_valid   output instruction valid
//   inst_ready   consumer accepts the instruction this cycle
//   inst         instruction (first) word
//   inst_lit     literal word, zero for one-word instructions
//   inst_has_lit instruction carried a literal
//   inst_pc      address of the instruction's first word
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [11:0] LIT_OPC  = 12'hFF1
) (
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] i_addr,
   input  logic [15:0] i_bus,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [15:0] inst,
   output logic [15:0] inst_lit,
   output logic        inst_has_lit,
   output logic [15:0] inst_pc
);

   typedef enum logic {
      S_WORD = 1'b0,   // next taken word is the first word of an instruction
      S_LIT  = 1'b1    // next taken word is the literal of a held Ldl
   } state_t;

   // fetch address tracking: fa_q is the address whose data is on i_bus now
   logic [15:0] fa_q, fa_d;
   logic        v_q, v_d;

   state_t      state_q, state_d;
   logic [15:0] hold_q, hold_d;     // held Ldl opcode word
   logic [15:0] hpc_q, hpc_d;       // address of the held Ldl word

   // registered output instruction
   logic        valid_q, valid_d;
   logic [15:0] inst_q, inst_d;
   logic [15:0] lit_q, lit_d;
   logic        has_lit_q, has_lit_d;
   logic [15:0] pc_q, pc_d;

   logic        space;
   logic        take;
   logic [15:0] fa_inc;

   always_comb begin
      // The output slot can accept a new instruction if it is empty or is
      // being drained this cycle.
      space  = !valid_q || inst_ready;
      take   = v_q && space && !redirect;
      fa_inc = fa_q + 16'd1;   // wraps FFFF -> 0000

      // When not taking, re-request the same address so i_bus keeps showing
      // the stalled word on the next cycle; this makes stalls bubble-free.
      if (redirect)
         i_addr = redirect_pc;
      else if (take)
         i_addr = fa_inc;
      else
         i_addr = fa_q;

      fa_d      = i_addr;
      v_d       = 1'b1;
      state_d   = state_q;
      hold_d    = hold_q;
      hpc_d     = hpc_q;
      valid_d   = valid_q && !inst_ready;   // drain on handshake, else hold
      inst_d    = inst_q;
      lit_d     = lit_q;
      has_lit_d = has_lit_q;
      pc_d      = pc_q;

      if (redirect) begin
         // A handshake coinciding with redirect still completes; anything
         // half-assembled in S_LIT is simply forgotten.
         valid_d = 1'b0;
         state_d = S_WORD;
      end else if (take) begin
         unique case (state_q)
            S_WORD: begin
               if (i_bus[15:4] == LIT_OPC) begin
                  hold_d  = i_bus;
                  hpc_d   = fa_q;
                  state_d = S_LIT;
               end else begin
                  valid_d   = 1'b1;
                  inst_d    = i_bus;
                  lit_d     = 16'h0000;
                  has_lit_d = 1'b0;
                  pc_d      = fa_q;
               end
            end
            S_LIT: begin
               // The literal is passed through untouched, never decoded.
               valid_d   = 1'b1;
               inst_d    = hold_q;
               lit_d     = i_bus;
               has_lit_d = 1'b1;
               pc_d      = hpc_q;
               state_d   = S_WORD;
            end
            default: state_d = S_WORD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fa_q      <= RESET_PC;
         v_q       <= 1'b0;
         state_q   <= S_WORD;
         hold_q    <= 16'h0000;
         hpc_q     <= 16'h0000;
         valid_q   <= 1'b0;
         inst_q    <= 16'h0000;
         lit_q     <= 16'h0000;
         has_lit_q <= 1'b0;
         pc_q      <= 16'h0000;
      end else begin
         fa_q      <= fa_d;
         v_q       <= v_d;
         state_q   <= state_d;
         hold_q    <= hold_d;
         hpc_q     <= hpc_d;
         valid_q   <= valid_d;
         inst_q    <= inst_d;
         lit_q     <= lit_d;
         has_lit_q <= has_lit_d;
         pc_q      <= pc_d;
      end
   end

   assign inst_valid   = valid_q;
   assign inst         = inst_q;
   assign inst_lit     = lit_q;
   assign inst_has_lit = has_lit_q;
   assign inst_pc      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A 256-word synchronous memory model answers
// i_addr on the following edge. Outputs are sampled 1 time unit after each
// rising edge ("step n" = n-th rising edge after reset release).
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   logic        clk;
   logic        rst;
   logic [15:0] i_addr;
   logic [15:0] i_bus;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst;
   logic [15:0] inst_lit;
   logic        inst_has_lit;
   logic [15:0] inst_pc;

   logic [15:0] mem [0:255];

   int checks = 0;
   int passes = 0;

   fetch_unit #(
      .RESET_PC (16'h0000),
      .LIT_OPC  (12'hFF1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_addr       (i_addr),
      .i_bus        (i_bus),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .inst_valid   (inst_valid),
      .inst_ready   (inst_ready),
      .inst         (inst),
      .inst_lit     (inst_lit),
      .inst_has_lit (inst_has_lit),
      .inst_pc      (inst_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) i_bus <= mem[i_addr[7:0]];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      inst_ready  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      redirect = 1'b0;
      redirect_pc = 16'h1234;
      inst_ready = 1'b0;
      #1;
      checks++;
      if ({inst_valid, inst, inst_lit, inst_has_lit, inst_pc} !== 50'd0)
         $display("FAIL reset_outputs: got v=%b inst=%h lit=%h hl=%b pc=%h, want all zero",
                  inst_valid, inst, inst_lit, inst_has_lit, inst_pc);
      else passes++;
      checks++;
      if (i_addr !== 16'h0000)
         $display("FAIL reset_i_addr: got %h, want 0000", i_addr);
      else passes++;
      redirect = 1'b1;
      #1;
      checks++;
      if (i_addr !== 16'h1234)
         $display("FAIL reset_redirect_addr: got %h, want 1234", i_addr);
      else passes++;
      redirect = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({inst_valid, i_addr} !== {1'b0, 16'h0000})
         $display("FAIL reset_held: got v=%b addr=%h, want v=0 addr=0000", inst_valid, i_addr);
      else passes++;
      $display("test_reset done");
   endtask

   task automatic test_program();
      apply_reset();
      step(); step();
      checks++;
      if (inst_valid !== 1'b0)
         $display("FAIL prog_no_early_valid: got %b, want 0", inst_valid);
      else passes++;
      step();  // 3
      checks++;
      if ({inst_valid, inst, inst_lit, inst_has_lit, inst_pc} !== {1'b1, 16'hFF10, 16'hAAAA, 1'b1, 16'h0000})
         $display("FAIL prog_ldl0: got v=%b inst=%h lit=%h hl=%b pc=%h, want 1 FF10 AAAA 1 0000",
                  inst_valid, inst, inst_lit, inst_has_lit, inst_pc);
      else passes++;
      step();  // 4
      checks++;
      if (inst_valid !== 1'b0)
         $display("FAIL prog_gap: got v=%b, want 0", inst_valid);
      else passes++;
      step();  // 5
      checks++;
      if ({inst_valid, inst, inst_lit, inst_has_lit, inst_pc} !== {1'b1, 16'hFF11, 16'h000F, 1'b1, 16'h0002})
         $display("FAIL prog_ldl2: got v=%b inst=%h lit=%h hl=%b pc=%h, want 1 FF11 000F 1 0002",
                  inst_valid, inst, inst_lit, inst_has_lit, inst_pc);
      else passes++;
      step();  // 6
      checks++;
      if ({inst_valid, inst, inst_lit, inst_has_lit, inst_pc} !== {1'b1, 16'hF501, 16'h0000, 1'b0, 16'h0004})
         $display("FAIL prog_one_word: got v=%b inst=%h lit=%h hl=%b pc=%h, want 1 F501 0000 0 0004",
                  inst_valid, inst, inst_lit, inst_has_lit, inst_pc);
      else passes++;
      $display("test_program done");
   endtask

   task automatic test_stall();
      logic [15:0] got_inst [3];
      logic [15:0] got_pc   [3];
      int n;
      for (int i = 0; i < 3; i++) begin
         got_inst[i] = 16'h0000;
         got_pc[i]   = 16'hDEAD;
      end
      apply_reset();
      step(); step(); step();
      inst_ready = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         step();
         checks++;
         if ({inst_valid, inst, inst_lit, inst_pc, i_addr} !== {1'b1, 16'hFF10, 16'hAAAA, 16'h0000, 16'h0002})
            $display("FAIL stall_hold_%0d: got v=%b inst=%h lit=%h pc=%h addr=%h, want 1 FF10 AAAA 0000 0002",
                     c, inst_valid, inst, inst_lit, inst_pc, i_addr);
         else passes++;
      end
      inst_ready = 1'b1;
      #1;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         if (inst_valid && inst_ready) begin
            got_inst[n] = inst;
            got_pc[n]   = inst_pc;
            n++;
         end
         step();
      end
      checks++;
      if (n !== 3)
         $display("FAIL stall_count: got %0d transfers, want 3", n);
      else passes++;
      checks++;
      if ({got_inst[0], got_pc[0], got_inst[1], got_pc[1], got_inst[2], got_pc[2]} !==
          {16'hFF10, 16'h0000, 16'hFF11, 16'h0002, 16'hF501, 16'h0004})
         $display("FAIL stall_seq: got %h@%h %h@%h %h@%h, want FF10@0000 FF11@0002 F501@0004",
                  got_inst[0], got_pc[0], got_inst[1], got_pc[1], got_inst[2], got_pc[2]);
      else passes++;
      $display("test_stall done");
   endtask

   task automatic test_redirect_lit();
      apply_reset();
      step(); step(); step(); step();  // FF11 opcode now held
      redirect    = 1'b1;
      redirect_pc = 16'h0004;
      #1;
      checks++;
      if (i_addr !== 16'h0004)
         $display("FAIL rlit_addr: got %h, want 0004", i_addr);
      else passes++;
      step();
      redirect = 1'b0;
      checks++;
      if (inst_valid !== 1'b0)
         $display("FAIL rlit_bubble: got v=%b inst=%h, want v=0", inst_valid, inst);
      else passes++;
      step();
      checks++;
      if ({inst_valid, inst, inst_has_lit, inst_pc} !== {1'b1, 16'hF501, 1'b0, 16'h0004})
         $display("FAIL rlit_next: got v=%b inst=%h hl=%b pc=%h, want 1 F501 0 0004",
                  inst_valid, inst, inst_has_lit, inst_pc);
      else passes++;
      $display("test_redirect_lit done");
   endtask

   task automatic test_wrap();
      apply_reset();
      step();
      redirect    = 1'b1;
      redirect_pc = 16'hFFFF;
      #1;
      checks++;
      if (i_addr !== 16'hFFFF)
         $display("FAIL wrap_addr0: got %h, want FFFF", i_addr);
      else passes++;
      step();
      redirect = 1'b0;
      #1;
      checks++;
      if (i_addr !== 16'h0000)
         $display("FAIL wrap_addr1: got %h, want 0000", i_addr);
      else passes++;
      step();
      checks++;
      if ({inst_valid, inst, inst_has_lit, inst_pc} !== {1'b1, 16'h0001, 1'b0, 16'hFFFF})
         $display("FAIL wrap_out: got v=%b inst=%h hl=%b pc=%h, want 1 0001 0 FFFF",
                  inst_valid, inst, inst_has_lit, inst_pc);
      else passes++;
      $display("test_wrap done");
   endtask

   task automatic test_async_reset();
      apply_reset();
      step(); step(); step();
      inst_ready = 1'b0;
      checks++;
      if (inst_valid !== 1'b1)
         $display("FAIL areset_pre: got v=%b, want 1", inst_valid);
      else passes++;
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({inst_valid, inst, inst_pc, i_addr} !== 49'd0)
         $display("FAIL areset_now: got v=%b inst=%h pc=%h addr=%h, want all zero",
                  inst_valid, inst, inst_pc, i_addr);
      else passes++;
      rst = 1'b0;
      inst_ready = 1'b1;
      step(); step();
      checks++;
      if (inst_valid !== 1'b0)
         $display("FAIL areset_quiet: got v=%b, want 0", inst_valid);
      else passes++;
      step();
      checks++;
      if ({inst_valid, inst, inst_lit, inst_pc} !== {1'b1, 16'hFF10, 16'hAAAA, 16'h0000})
         $display("FAIL areset_restart: got v=%b inst=%h lit=%h pc=%h, want 1 FF10 AAAA 0000",
                  inst_valid, inst, inst_lit, inst_pc);
      else passes++;
      $display("test_async_reset done");
   endtask

   task automatic test_redirect_handshake();
      apply_reset();
      step(); step(); step();   // FF10 valid, ready=1
      redirect    = 1'b1;
      redirect_pc = 16'h0004;
      step();
      redirect = 1'b0;
      checks++;
      if (inst_valid !== 1'b0)
         $display("FAIL rhs_accepted: got v=%b inst=%h, want v=0", inst_valid, inst);
      else passes++;
      step();
      checks++;
      if ({inst_valid, inst, inst_pc} !== {1'b1, 16'hF501, 16'h0004})
         $display("FAIL rhs_next: got v=%b inst=%h pc=%h, want 1 F501 0004",
                  inst_valid, inst, inst_pc);
      else passes++;
      $display("test_redirect_handshake done");
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_inst [4];
      exp_inst[0] = 16'h1234;
      exp_inst[1] = 16'h2345;
      exp_inst[2] = 16'h3456;
      exp_inst[3] = 16'h4567;
      apply_reset();
      step();
      redirect    = 1'b1;
      redirect_pc = 16'h000A;
      step();
      redirect = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         checks++;
         if ({inst_valid, inst, inst_lit, inst_has_lit, inst_pc} !==
             {1'b1, exp_inst[k], 16'h0000, 1'b0, 16'h000A + 16'(k)})
            $display("FAIL b2b_%0d: got v=%b inst=%h lit=%h hl=%b pc=%h, want 1 %h 0000 0 %h",
                     k, inst_valid, inst, inst_lit, inst_has_lit, inst_pc,
                     exp_inst[k], 16'h000A + 16'(k));
         else passes++;
      end
      $display("test_back_to_back done");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
      mem[0]    = 16'hFF10;
      mem[1]    = 16'hAAAA;
      mem[2]    = 16'hFF11;
      mem[3]    = 16'h000F;
      mem[4]    = 16'hF501;
      mem[10]   = 16'h1234;
      mem[11]   = 16'h2345;
      mem[12]   = 16'h3456;
      mem[13]   = 16'h4567;
      mem[255]  = 16'h0001;

      test_reset();
      test_program();
      test_stall();
      test_redirect_lit();
      test_wrap();
      test_async_reset();
      test_redirect_handshake();
      test_back_to_back();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit, got no finish, want finish");
      $fatal(1);
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: first fetch address after reset.
REQ-002 SHALL have parameter LIT_OPC, default 12'hFF1: a word with [15:4]==LIT_OPC is a two-word (Ldl) instruction.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  clock; all state changes on posedge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 i_addr  output  16  instruction address to memory; combinational.
REQ-007 i_bus  input  16  instruction word from memory: mem[i_addr] sampled at the previous posedge.
REQ-008 redirect  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-009 redirect_pc  input  16  target address, valid when redirect=1.
REQ-010 inst_valid  output  1  output instruction valid.
REQ-011 inst_ready  input  1  decoder accepts the instruction; transfer occurs when inst_valid&&inst_ready at a posedge.
REQ-012 inst  output  16  instruction word.
REQ-013 inst_lit  output  16  literal word; 0 when inst_has_lit=0.
REQ-014 inst_has_lit  output  1  instruction carried a literal.
REQ-015 inst_pc  output  16  address of the instruction's first word.

Function
REQ-016 SHALL keep fa_q, the address whose data is on i_bus this cycle, and v_q, which is set when that data is valid.
REQ-017 SHALL define space = !inst_valid || inst_ready; take = v_q && space && !redirect.
REQ-018 SHALL drive i_addr = redirect ? redirect_pc : (take ? fa_q+1 : fa_q), giving a zero-bubble stall because i_bus re-presents the same word while stalled.
REQ-019 SHALL load fa_q <= i_addr and v_q <= 1 each posedge.
REQ-020 SHALL compute fa_q+1 modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-021 SHALL have FSM states WORD (expect first word) and LIT (expect literal).
REQ-022 WORD with take and i_bus[15:4]==LIT_OPC: hold_q<=i_bus, hpc_q<=fa_q, go to LIT, output unchanged except it drains if inst_ready.
REQ-023 WORD with take and not LIT_OPC: load output {inst=i_bus, inst_lit=0, has_lit=0, inst_pc=fa_q}, inst_valid<=1, stay in WORD.
REQ-024 LIT with take: load output {inst=hold_q, inst_lit=i_bus, has_lit=1, inst_pc=hpc_q}, inst_valid<=1, go to WORD; the literal word is never decoded as an opcode.
REQ-025 With no take and inst_valid&&inst_ready: inst_valid<=0.
REQ-026 Output latency SHALL be one posedge from a taken word to inst_valid, and one-word instructions SHALL sustain one per cycle when inst_ready=1.
REQ-027 Output registers SHALL hold stable while inst_valid&&!inst_ready.
REQ-028 redirect SHALL take priority at a posedge: inst_valid<=0, FSM<=WORD, the held first word is discarded, and fa_q<=redirect_pc.
REQ-029 A handshake in the same cycle as redirect counts as completed.
REQ-030 The first output after redirect SHALL be from redirect_pc, two posedges later for a one-word instruction.
REQ-031 redirect while in LIT SHALL drop the partial instruction and never emit it.

Reset
REQ-032 rst=1 SHALL immediately force fa_q=RESET_PC, v_q=0, FSM=WORD, inst_valid=0, inst=0, inst_lit=0, inst_has_lit=0, inst_pc=0, hold_q=0, hpc_q=0.
REQ-033 With rst=1, i_addr SHALL equal RESET_PC unless redirect=1.
REQ-034 Reset asserted mid-instruction, including in LIT or while stalled, SHALL abandon all in-flight words; fetch restarts at RESET_PC.

Verification
REQ-035 Memory holds mem[0..4] = FF10, AAAA, FF11, 000F, F501 with inst_ready=1; release reset -> outputs at 3rd, 5th and 6th posedge are: inst=FF10/lit=AAAA/pc=0; FF11/000F/pc=2; F501/has_lit=0/pc=4.
REQ-036 Same program, inst_ready=0 for 4 cycles after the first inst_valid -> inst stays FF10 and i_addr stays constant; after release the sequence continues with no word lost or duplicated.
REQ-037 redirect=1 with redirect_pc=0004 while FSM=LIT (after FF11 taken) -> FF11 is never emitted; next output is F501 pc=4.
REQ-038 redirect to FFFF with mem[FFFF mod 256]=0001 -> i_addr sequence FFFF, 0000; output 0001 with pc=FFFF.
REQ-039 rst pulsed asynchronously between edges while inst_valid=1 -> inst_valid=0 before the next posedge; fetch restarts at RESET_PC and the first output is pc=0.
REQ-040 redirect in the same cycle as inst_valid&&inst_ready -> the current instruction counts as accepted, is not re-presented, and the next output is from redirect_pc.
